// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO buffering ALU {flag, result} words between an ALU and its consumer.
// Optional saturating err/overflow push counters are built when ALU_FIFO_STATS_EN is defined.
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_clr,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_result,
  input  logic [3:0]               i_flag,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_result,
  output logic [3:0]               o_flag,
  output logic [$clog2(DEPTH):0]   o_count,
`ifdef ALU_FIFO_STATS_EN
  output logic [CNT_W-1:0]         o_err_cnt,
  output logic [CNT_W-1:0]         o_ovf_cnt,
`endif
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 4;

  // Handshake: a word moves on a rising edge only when valid && ready on that side;
  // o_ready and o_valid depend solely on registered occupancy, never on same-cycle inputs.
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign o_ready = !o_full;
  assign o_valid = !o_empty;
  assign o_count = count;

  assign push = i_valid && o_ready && !i_clr;
  assign pop  = o_valid && i_ready && !i_clr;

  assign {o_flag, o_result} = mem[rd_ptr];

  // Storage is not reset; occupancy alone decides what is meaningful.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_flag, i_result};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_FIFO_STATS_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_err_cnt <= '0;
      o_ovf_cnt <= '0;
    end else if (i_clr) begin
      o_err_cnt <= '0;
      o_ovf_cnt <= '0;
    end else if (push) begin
      if (i_flag[0] && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 1'b1;
      if (i_flag[3] && (o_ovf_cnt != '1)) o_ovf_cnt <= o_ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: the driver queues expected words, a negedge monitor checks every pop.
// Stats checks (including a CNT_W=2 saturation instance) are built when ALU_FIFO_STATS_EN is defined.
module tb_alu_result_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             i_clk;
  logic             i_rstn;
  logic             i_clr;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_result;
  logic [3:0]       i_flag;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic [3:0]       o_flag;
  logic [2:0]       o_count;
  logic             o_full;
  logic             o_empty;
`ifdef ALU_FIFO_STATS_EN
  logic [7:0]       o_err_cnt;
  logic [7:0]       o_ovf_cnt;
  logic [1:0]       s_err_cnt;
  logic [1:0]       s_ovf_cnt;
  logic             s_ready, s_valid, s_full, s_empty;
  logic [WIDTH-1:0] s_result;
  logic [3:0]       s_flag;
  logic [2:0]       s_count;
`endif

  int total = 0;
  int bad   = 0;
  int mcnt  = 0;
  logic [WIDTH+3:0] exp_q[$];

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(i_clr), .i_valid(i_valid), .o_ready(o_ready),
    .i_result(i_result), .i_flag(i_flag), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_flag(o_flag), .o_count(o_count),
`ifdef ALU_FIFO_STATS_EN
    .o_err_cnt(o_err_cnt), .o_ovf_cnt(o_ovf_cnt),
`endif
    .o_full(o_full), .o_empty(o_empty)
  );

`ifdef ALU_FIFO_STATS_EN
  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(i_clr), .i_valid(i_valid), .o_ready(s_ready),
    .i_result(i_result), .i_flag(i_flag), .o_valid(s_valid), .i_ready(i_ready),
    .o_result(s_result), .o_flag(s_flag), .o_count(s_count),
    .o_err_cnt(s_err_cnt), .o_ovf_cnt(s_ovf_cnt),
    .o_full(s_full), .o_empty(s_empty)
  );
`endif

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected word is queued when the driver issues an accepted push.
  task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic [3:0] f,
                      input logic rdy, input logic clr);
    logic do_push, do_pop;
    i_valid  = v;
    i_result = d;
    i_flag   = f;
    i_ready  = rdy;
    i_clr    = clr;
    if (clr) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      do_push = v && (mcnt < DEPTH);
      do_pop  = rdy && (mcnt > 0);
      if (do_push) exp_q.push_back({f, d});
      mcnt = mcnt + int'(do_push) - int'(do_pop);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_clr   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(o_count), 32'(mcnt));
    check({tag, "_valid"}, 32'(o_valid), 32'(mcnt != 0));
    check({tag, "_ready"}, 32'(o_ready), 32'(mcnt != DEPTH));
    check({tag, "_full"},  32'(o_full),  32'(mcnt == DEPTH));
    check({tag, "_empty"}, 32'(o_empty), 32'(mcnt == 0));
  endtask

  // scoreboard monitor: a pop happens at the coming edge whenever valid && ready
  always @(negedge i_clk) begin
    if (i_rstn && !i_clr && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got %0h expected none", {o_flag, o_result});
      end else begin
        check("pop_word", 32'({o_flag, o_result}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    i_rstn = 1'b0; i_clr = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_result = '0; i_flag = '0;
    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full",  32'(o_full),  32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // single push with downstream stalled: visible the cycle after the edge
    tick(1'b1, 4'h3, 4'b0100, 1'b0, 1'b0);
    check("one_valid",  32'(o_valid),  32'd1);
    check("one_result", 32'(o_result), 32'h3);
    check("one_flag",   32'(o_flag),   32'b0100);
    check("one_count",  32'(o_count),  32'd1);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    check_state("one_drain");

    // fill, overflow attempt, drain
    for (int i = 1; i <= 4; i++) tick(1'b1, WIDTH'(i), 4'b0000, 1'b0, 1'b0);
    check("fill_full",  32'(o_full),  32'd1);
    check("fill_ready", 32'(o_ready), 32'd0);
    check("fill_count", 32'(o_count), 32'd4);
    tick(1'b1, 4'h5, 4'b1000, 1'b0, 1'b0);
    check("ovr_count", 32'(o_count), 32'd4);
    check("ovr_head",  32'(o_result), 32'h1);
    for (int i = 0; i < 4; i++) tick(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(o_empty), 32'd1);
    check_state("drain");

    // steady streaming across pointer wrap
    tick(1'b1, 4'h0, 4'b0010, 1'b0, 1'b0);
    tick(1'b1, 4'h1, 4'b0100, 1'b0, 1'b0);
    for (int i = 2; i < 12; i++) begin
      tick(1'b1, WIDTH'(i), 4'(i), 1'b1, 1'b0);
      check("stream_count", 32'(o_count), 32'd2);
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    check_state("stream_end");

    // clear beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) tick(1'b1, WIDTH'(9 + i), 4'b0001, 1'b0, 1'b0);
    check("pre_clr_count", 32'(o_count), 32'd3);
    tick(1'b1, 4'h7, 4'b1000, 1'b1, 1'b1);
    check("clr_count", 32'(o_count), 32'd0);
    check("clr_valid", 32'(o_valid), 32'd0);
    check("clr_ready", 32'(o_ready), 32'd1);
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    check("clr_nostore", 32'(o_count), 32'd0);

    // asynchronous reset between edges
    tick(1'b1, 4'h6, 4'b0000, 1'b0, 1'b0);
    tick(1'b1, 4'h7, 4'b0000, 1'b0, 1'b0);
    check("pre_arst_count", 32'(o_count), 32'd2);
    #2 i_rstn = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_count", 32'(o_count), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd1);
    exp_q.delete();
    mcnt = 0;
    #2 i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    tick(1'b1, 4'hA, 4'b0100, 1'b0, 1'b0);
    check("post_arst_result", 32'(o_result), 32'hA);
    check("post_arst_count",  32'(o_count),  32'd1);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    check_state("post_arst_drain");

`ifdef ALU_FIFO_STATS_EN
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    check("stat_clr_err", 32'(o_err_cnt), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, WIDTH'(i), 4'b1001, 1'b0, 1'b0);
    tick(1'b1, 4'h3, 4'b0010, 1'b0, 1'b0);
    check("stat_err", 32'(o_err_cnt), 32'd3);
    check("stat_ovf", 32'(o_ovf_cnt), 32'd3);
    check("sat_err_3", 32'(s_err_cnt), 32'd3);
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, WIDTH'(i), 4'b0001, 1'b1, 1'b0);
    check("stat_err5", 32'(o_err_cnt), 32'd5);
    check("sat_err",   32'(s_err_cnt), 32'd3);
    check("sat_ovf",   32'(s_ovf_cnt), 32'd0);
    tick(1'b0, '0, '0, 1'b1, 1'b0);
`endif

    tick(1'b0, '0, '0, 1'b0, 1'b0);
    check("queue_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001: Parameter WIDTH, default 4, result word width; matches ALU o_result width.
REQ-002: Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-003: Parameter CNT_W, default 8, width of statistics counters.
REQ-004: i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005: i_rstn  input  1  asynchronous, active-low reset.
REQ-006: i_clr  input  1  synchronous flush of FIFO contents and statistics.
REQ-007: i_valid  input  1  upstream ALU result valid.
REQ-008: o_ready  output  1  FIFO can accept a word.
REQ-009: i_result  input  WIDTH  ALU result word.
REQ-010: i_flag  input  4  ALU flags: [0] err, [1] neg, [2] pos, [3] overflow.
REQ-011: o_valid  output  1  head entry available.
REQ-012: i_ready  input  1  downstream accepts head entry.
REQ-013: o_result  output  WIDTH  head entry result.
REQ-014: o_flag  output  4  head entry flags, same bit mapping as i_flag.
REQ-015: o_count  output  log2(DEPTH)+1  current occupancy.
REQ-016: o_full / o_empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-017: o_err_cnt, o_ovf_cnt  output  CNT_W each  statistics, present only with ALU_FIFO_STATS_EN.

Function
REQ-018: Push SHALL occur on a rising edge when i_valid && o_ready; {i_flag, i_result} written at the write pointer.
REQ-019: o_ready SHALL equal !o_full, combinationally from registered state; no bypass push into a full FIFO, even with a simultaneous pop.
REQ-020: Pop SHALL occur on a rising edge when o_valid && i_ready; o_valid SHALL equal !o_empty.
REQ-021: o_result/o_flag SHALL present the head entry in first-word-fall-through form; their value is don't-care while o_empty.
REQ-022: Latency: word pushed at edge k SHALL be visible on o_result/o_flag with o_valid=1 in the cycle after edge k if the FIFO was empty.
REQ-023: Simultaneous push and pop while neither full nor empty SHALL leave o_count unchanged and preserve order.
REQ-024: Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strict first-in-first-out across wrap.
REQ-025: o_count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-026: i_valid while full SHALL be ignored (word not stored, no state change); upstream holds the word.
REQ-027: i_clr SHALL take priority over push and pop in the same cycle: pointers, o_count and statistics cleared; o_ready=1, o_valid=0 in the following cycle.
REQ-028: Storage contents need not be cleared by reset or i_clr.

Reset
REQ-029: On i_rstn low, asynchronously: pointers=0, o_count=0, o_empty=1, o_full=0, o_valid=0, o_ready=1, statistics=0.
REQ-030: Reset asserted mid-operation SHALL discard all stored entries; first push after release is the first word read.
REQ-031: Reset release SHALL take effect on the first rising edge after i_rstn goes high.

Configuration
REQ-032: Macro ALU_FIFO_STATS_EN defined: o_err_cnt increments on each accepted push with i_flag[0]=1; o_ovf_cnt increments on each accepted push with i_flag[3]=1; both saturate at all-ones.
REQ-033: Macro ALU_FIFO_STATS_EN undefined: o_err_cnt and o_ovf_cnt ports and counter logic are absent; FIFO behaviour unchanged.

Verification
REQ-034: Reset, then push result=4'h3 flag=4'b0100 with i_ready=0 -> next cycle o_valid=1, o_result=3, o_flag=0100, o_count=1.
REQ-035: Push 4 words 1,2,3,4 with i_ready=0 -> o_full=1, o_ready=0; fifth push 5 ignored; drain -> reads 1,2,3,4, o_empty=1.
REQ-036: Fill to 2, then 10 cycles of simultaneous push/pop with incrementing data -> o_count stays 2, output sequence in order across pointer wrap.
REQ-037: FIFO holding 3 entries, assert i_clr together with i_valid and i_ready -> next cycle o_count=0, o_valid=0, o_ready=1, pushed word not stored.
REQ-038: With ALU_FIFO_STATS_EN, push 3 words with flag=4'b1001 and 1 with flag=4'b0010 -> o_err_cnt=3, o_ovf_cnt=3; with CNT_W=2, 5 err pushes -> o_err_cnt=3 (saturated).
REQ-039: Assert i_rstn low asynchronously between edges with 2 entries stored -> o_valid=0, o_count=0 immediately; after release, new push 4'hA is first read.
